// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and the per-port receivers.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int BAUD_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // A baud control word of 0 would never let the bit counter terminate, so it acts as 1.
  function automatic logic [BAUD_W-1:0] baud_period(input logic [BAUD_W-1:0] baud);
    return (baud == '0) ? BAUD_W'(1) : baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count. The head entry is readable
// combinationally so a consumer can pop and use the byte at the same edge.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  // A push against a full FIFO is dropped outright, regardless of any pop in the same cycle.
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  assign o_full  = (count_reg == (AW + 1)'(DEPTH));
  assign o_empty = (count_reg == '0);
  assign o_count = count_reg;
  assign o_data  = mem[rd_ptr_reg];

  // Storage write; contents need no reset since the count defines what is valid.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= i_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks push/pop balance.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter, LSB first, 8N1 by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [UART_DATA_W-1:0] i_D,
  input  logic                   i_write,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_busy,
  input  logic [BAUD_W-1:0]      i_baud,
  output logic                   o_tx
);

  logic [UART_DATA_W-1:0] fifo_q;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [AW:0]            fifo_count;
  logic                   fifo_pop;
  logic                   has_data;
  logic                   bit_done;
  logic                   load_frame;

  tx_state_e              state_reg, state_next;
  logic [BAUD_W-1:0]      baud_cnt_reg, baud_cnt_next;
  logic [BAUD_W-1:0]      period_reg, period_next;
  logic [2:0]             bit_idx_reg, bit_idx_next;
  logic [UART_DATA_W-1:0] shift_reg, shift_next;
  logic                   tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
  logic                   parity_reg, parity_next;
`endif

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W),
    .AW    (AW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_write),
    .i_pop   (fifo_pop),
    .i_data  (i_D),
    .o_data  (fifo_q),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign has_data = (fifo_count != '0);
  assign bit_done = (baud_cnt_reg == period_reg - BAUD_W'(1));
  assign o_full   = fifo_full;
  assign o_empty  = fifo_empty;
  assign o_busy   = (state_reg != IDLE);
  assign o_tx     = tx_reg;

  // Next-state logic: each line state lasts P cycles; a new frame is loaded from IDLE
  // or straight out of STOP so back-to-back frames have no idle gap.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    period_next   = period_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    tx_next       = tx_reg;
    fifo_pop      = 1'b0;
    load_frame    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next   = parity_reg;
`endif
    unique case (state_reg)
      IDLE: begin
        tx_next    = 1'b1;
        load_frame = has_data;
      end
      START: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          tx_next       = shift_reg[0];
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_next    = parity_reg;
            state_next = PARITY;
`else
            tx_next    = 1'b1;
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
            shift_next   = shift_reg >> 1;
            tx_next      = shift_reg[1];
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      PARITY: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          tx_next       = 1'b1;
          state_next    = STOP;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          tx_next       = 1'b1;
          state_next    = IDLE;
          load_frame    = has_data;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
    // Frame load: pop the head byte, latch this frame's bit period, start bit goes out now.
    if (load_frame) begin
      fifo_pop      = 1'b1;
      shift_next    = fifo_q;
      period_next   = baud_period(i_baud);
      baud_cnt_next = '0;
      tx_next       = 1'b0;
      state_next    = START;
`ifdef UART_TX_PARITY_EN
      parity_next   = ^fifo_q;
`endif
    end
  end

  // State registers; reset aborts any frame and forces the line high at once.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      period_reg   <= BAUD_W'(1);
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      period_reg   <= period_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo. Written bytes are queued and
// each serial frame seen on the line is checked cycle by cycle against the queue head.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  d;
  logic        wr;
  logic [15:0] baud;
  logic        full, empty, busy, tx;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(16)) dut (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .i_D     (d),
    .i_write (wr),
    .o_full  (full),
    .o_empty (empty),
    .o_busy  (busy),
    .i_baud  (baud),
    .o_tx    (tx)
  );

  // Drive one write for one clock edge; accept says whether the byte should be sent.
  task automatic push_write(input logic [7:0] b, input bit accept);
    d  = b;
    wr = 1'b1;
    if (accept) sb_q.push_back(b);
    $display("[TB] write 0x%02h expect_%s", b, accept ? "accepted" : "dropped");
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Check the frame whose start bit is the next low on the line; gap = cycles waited.
  task automatic check_frame(input string name, input int p, output int gap);
    logic [7:0]  exp, got;
    logic [10:0] bits;
    int nbits, bad, bj, bc;
    logic btx, bbusy;
    gap = 0;
    while (tx !== 1'b0 && gap < 4000) begin
      @(negedge clk);
      gap++;
    end
    tests++;
    if (tx !== 1'b0) begin
      fails++;
      $display("FAIL %s start_timeout tx=%b required=0 after %0d cycles", name, tx, gap);
      return;
    end
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s unexpected_frame queue empty", name);
      return;
    end
    exp  = sb_q.pop_front();
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = exp[i];
`ifdef UART_TX_PARITY_EN
    bits[9]  = ^exp;
    bits[10] = 1'b1;
    nbits    = 11;
`else
    bits[9]  = 1'b1;
    nbits    = 10;
`endif
    bad = 0; bj = 0; bc = 0; btx = 1'b0; bbusy = 1'b0; got = '0;
    for (int j = 0; j < nbits; j++) begin
      for (int c = 0; c < p; c++) begin
        if (tx !== bits[j] || busy !== 1'b1) begin
          if (bad == 0) begin
            bj = j; bc = c; btx = tx; bbusy = busy;
          end
          bad++;
        end
        if (j >= 1 && j <= 8 && c == p / 2) got[j-1] = tx;
        @(negedge clk);
      end
    end
    if (bad != 0) begin
      fails++;
      $display("FAIL %s line_shape byte=0x%02h bit=%0d cycle=%0d tx=%b busy=%b required tx=%b busy=1",
               name, exp, bj, bc, btx, bbusy, bits[bj]);
    end
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s decode got=0x%02h required=0x%02h", name, got, exp);
    end
    $display("[TB] %s frame byte=0x%02h decoded=0x%02h gap=%0d", name, exp, got, gap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr = 1'b0; d = '0; baud = 16'd4;
    repeat (3) @(negedge clk);
    tests++; if (tx !== 1'b1)    begin fails++; $display("FAIL reset_tx got=%b required=1", tx); end
    tests++; if (full !== 1'b0)  begin fails++; $display("FAIL reset_full got=%b required=0", full); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b required=1", empty); end
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy got=%b required=0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int gap;
    baud = 16'd4;
    push_write(8'h55, 1'b1);
    tests++; if (tx !== 1'b1 || empty !== 1'b0) begin
      fails++; $display("FAIL single_accept tx=%b empty=%b required tx=1 empty=0", tx, empty);
    end
    @(negedge clk);
    tests++; if (tx !== 1'b0 || empty !== 1'b1) begin
      fails++; $display("FAIL single_pop tx=%b empty=%b required tx=0 empty=1", tx, empty);
    end
    check_frame("single", 4, gap);
    tests++; if (gap != 0) begin fails++; $display("FAIL single_gap got=%0d required=0", gap); end
    tests++; if (busy !== 1'b0 || tx !== 1'b1) begin
      fails++; $display("FAIL single_end busy=%b tx=%b required busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    baud = 16'd2;
    push_write(8'hA3, 1'b1);
    push_write(8'h0F, 1'b1);
    check_frame("b2b_first", 2, gap);
    tests++; if (gap != 0) begin fails++; $display("FAIL b2b_first_gap got=%0d required=0", gap); end
    check_frame("b2b_second", 2, gap);
    tests++; if (gap != 0) begin fails++; $display("FAIL b2b_contiguous got=%0d required=0", gap); end
    tests++; if (busy !== 1'b0 || empty !== 1'b1) begin
      fails++; $display("FAIL b2b_end busy=%b empty=%b required busy=0 empty=1", busy, empty);
    end
  endtask

  task automatic test_overflow();
    int gap, gap_bad;
    baud = 16'd100;
    gap_bad = 0;
    fork
      begin
        for (int i = 0; i < 18; i++) begin
          if (i == 16) begin
            tests++; if (full !== 1'b0) begin fails++; $display("FAIL ovf_not_full got=%b required=0", full); end
          end
          if (i == 17) begin
            tests++; if (full !== 1'b1) begin fails++; $display("FAIL ovf_full got=%b required=1", full); end
          end
          push_write(8'(i), i < 17);
        end
        tests++; if (full !== 1'b1 || empty !== 1'b0) begin
          fails++; $display("FAIL ovf_drop full=%b empty=%b required full=1 empty=0", full, empty);
        end
      end
      begin
        for (int k = 0; k < 17; k++) begin
          check_frame("ovf", 100, gap);
          if (k > 0 && gap != 0) gap_bad++;
        end
      end
    join
    tests++; if (gap_bad != 0) begin fails++; $display("FAIL ovf_gaps got=%0d required=0", gap_bad); end
    tests++; if (sb_q.size() != 0 || empty !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL ovf_drain queue=%0d empty=%b busy=%b required 0/1/0", sb_q.size(), empty, busy);
    end
  endtask

  task automatic test_baud_edges();
    int gap;
    baud = 16'd0;
    push_write(8'hFF, 1'b1);
    check_frame("baud0", 1, gap);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL baud0_len busy=%b required=0", busy); end
    baud = 16'd3;
    push_write(8'h3C, 1'b1);
    push_write(8'hC3, 1'b1);
    fork
      begin
        repeat (7) @(negedge clk);
        baud = 16'd8;
      end
    join_none
    check_frame("baud_keep3", 3, gap);
    check_frame("baud_next8", 8, gap);
    tests++; if (gap != 0) begin fails++; $display("FAIL baud_change_gap got=%0d required=0", gap); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    baud = 16'd5;
    push_write(8'h81, 1'b1);
    push_write(8'h42, 1'b1);
    repeat (22) @(negedge clk);
    tests++; if (tx !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL rstmid_bit3 tx=%b busy=%b required tx=0 busy=1", tx, busy);
    end
    rst_n = 1'b0;
    #1;
    tests++; if (tx !== 1'b1 || empty !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
      fails++; $display("FAIL rstmid_abort tx=%b empty=%b busy=%b full=%b required 1/1/0/0", tx, empty, busy, full);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rstmid_quiet cycles_active=%0d required=0", bad); end
    $display("[TB] reset mid-frame aborted, line quiet");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int gap;
    baud = 16'd1;
    push_write(8'h07, 1'b1);
    check_frame("parity", 1, gap);
    tests++; if (busy !== 1'b0 || tx !== 1'b1) begin
      fails++; $display("FAIL parity_len busy=%b tx=%b required busy=0 tx=1", busy, tx);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_baud_edges();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
